slink_channel_despread_fifo: RTL and testbench

//  Parametrised despread compactor with output buffering for the channel allocator RX path.

---
 rtl/slink_channel_despread_fifo_pkg.sv | 12 +
 rtl/slink_channel_compact.sv | 32 +++
 rtl/slink_channel_despread_fifo.sv | 107 ++++++++++
 tb/tb_slink_channel_despread_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/slink_channel_despread_fifo_pkg.sv
// Shared defaults and a small index helper for the RX despread compactor/FIFO slice.
package slink_channel_despread_fifo_pkg;

  localparam int unsigned DefaultNumChan = 8;
  localparam int unsigned DefaultDepth   = 2;

  // Wrap-around increment for indices in 0..limit-1; limit need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned limit);
    return (idx + 1 >= limit) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/slink_channel_compact.sv
// Combinational lane compactor: packs the valid lanes of a beat into the low lanes,
// preserving their relative order, and reports how many there were.
module slink_channel_compact
  import slink_channel_despread_fifo_pkg::*;
#(
  parameter type         element_t = logic [15:0],
  parameter int unsigned NumChan   = DefaultNumChan,
  localparam int unsigned CntW     = $clog2(NumChan + 1)
) (
  input  logic     [NumChan-1:0] valid_i,
  input  element_t [NumChan-1:0] data_i,
  output element_t [NumChan-1:0] data_o,
  output logic     [CntW-1:0]    cnt_o
);

  // pc is the running popcount of lanes below i, i.e. the destination lane of lane i.
  always_comb begin
    logic [CntW-1:0] pc;
    data_o = '0;
    pc     = '0;
    for (int unsigned i = 0; i < NumChan; i++) begin
      if (valid_i[i]) begin
        for (int unsigned j = 0; j <= i; j++) begin
          if (pc == CntW'(j)) data_o[j] = data_i[i];
        end
      end
      pc = pc + CntW'(valid_i[i]);
    end
    cnt_o = pc;
  end

endmodule

// File: rtl/slink_channel_despread_fifo.sv
// RX-path despread compactor followed by a Depth-entry FIFO of compacted beats.
// Full throughput, including simultaneous push and pop when full.
module slink_channel_despread_fifo
  import slink_channel_despread_fifo_pkg::*;
#(
  parameter type         element_t = logic [15:0],
  parameter int unsigned NumChan   = DefaultNumChan,
  parameter int unsigned Depth     = DefaultDepth,
  localparam int unsigned CntW     = $clog2(NumChan + 1),
  localparam int unsigned UsageW   = $clog2(Depth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic     [NumChan-1:0] valid_i,
  output logic                   ready_o,
  input  element_t [NumChan-1:0] data_i,
  output logic     [NumChan-1:0] valid_o,
  input  logic                   ready_i,
  output element_t [NumChan-1:0] data_o,
  output logic     [CntW-1:0]    cnt_o,
  output logic     [UsageW-1:0]  usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  element_t [NumChan-1:0] cmp_data;
  logic     [CntW-1:0]    cmp_cnt;

  element_t [NumChan-1:0] mem_data [Depth];
  logic     [CntW-1:0]    mem_cnt  [Depth];

  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [UsageW-1:0] usage_q;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  slink_channel_compact #(
    .element_t (element_t),
    .NumChan   (NumChan)
  ) u_compact (
    .valid_i (valid_i),
    .data_i  (data_i),
    .data_o  (cmp_data),
    .cnt_o   (cmp_cnt)
  );

  assign empty = (usage_q == '0);
  assign full  = (usage_q == UsageW'(Depth));

  // ready_i feeds ready_o combinationally so a full FIFO can push and pop in one cycle.
  assign ready_o = ~(rst_i | clear_i) & (~full | ready_i);
  assign push    = (|valid_i) & ready_o;
  assign pop     = ~empty & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
    end else begin
      if (push) wr_ptr <= PtrW'(wrap_inc(32'(wr_ptr), Depth));
      if (pop)  rd_ptr <= PtrW'(wrap_inc(32'(rd_ptr), Depth));
      if (push && !pop)      usage_q <= usage_q + UsageW'(1);
      else if (pop && !push) usage_q <= usage_q - UsageW'(1);
    end
  end

  // Entry payload needs no reset: it is only observed through the occupancy-gated head.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= cmp_data;
      mem_cnt[wr_ptr]  <= cmp_cnt;
    end
  end

  always_comb begin
    data_o  = '0;
    cnt_o   = '0;
    valid_o = '0;
    if (!empty) begin
      data_o = mem_data[rd_ptr];
      cnt_o  = mem_cnt[rd_ptr];
    end
    for (int unsigned i = 0; i < NumChan; i++) begin
      valid_o[i] = (CntW'(i) < cnt_o);
    end
  end

  assign usage_o = usage_q;

  a_valid_mask : assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o == ~({NumChan{1'b1}} << cnt_o));

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    (full && !ready_i) |-> !push);

  a_usage_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    usage_q <= UsageW'(Depth));

  a_upstream_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    ((|valid_i) && !ready_o && !clear_i) |=> ($stable(valid_i) && $stable(data_i)));

endmodule

// File: tb/tb_slink_channel_despread_fifo.sv
// Bench for slink_channel_despread_fifo: Depth=2 and Depth=3 instances, NumChan=4, 8-bit lanes.
module tb_slink_channel_despread_fifo;

  typedef struct packed {
    logic [3:0][7:0] data;
    logic [2:0]      cnt;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]      valid_i [2];
  logic [3:0][7:0] data_i  [2];
  logic            ready_i [2];
  logic            clear_i [2];
  logic            ready_o [2];
  logic [3:0]      valid_o [2];
  logic [3:0][7:0] data_o  [2];
  logic [2:0]      cnt_o   [2];
  logic [1:0]      usage_o [2];

  int unsigned passed = 0;
  int unsigned fails  = 0;
  int unsigned total  = 0;
  int unsigned depth_m;
  string       phase;
  beat_t       q[$];

  always #5 clk = ~clk;

  slink_channel_despread_fifo #(
    .element_t (logic [7:0]),
    .NumChan   (4),
    .Depth     (2)
  ) u_dut_d2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear_i[0]),
    .valid_i (valid_i[0]),
    .ready_o (ready_o[0]),
    .data_i  (data_i[0]),
    .valid_o (valid_o[0]),
    .ready_i (ready_i[0]),
    .data_o  (data_o[0]),
    .cnt_o   (cnt_o[0]),
    .usage_o (usage_o[0])
  );

  slink_channel_despread_fifo #(
    .element_t (logic [7:0]),
    .NumChan   (4),
    .Depth     (3)
  ) u_dut_d3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear_i[1]),
    .valid_i (valid_i[1]),
    .ready_o (ready_o[1]),
    .data_i  (data_i[1]),
    .valid_o (valid_o[1]),
    .ready_i (ready_i[1]),
    .data_o  (data_o[1]),
    .cnt_o   (cnt_o[1]),
    .usage_o (usage_o[1])
  );

  // Reference compaction: collect the valid lanes in order, then lay them out from lane 0.
  function automatic beat_t compact(input logic [3:0] v, input logic [31:0] dat);
    beat_t      b;
    logic [7:0] lanes[$];
    b = '0;
    for (int i = 0; i < 4; i++) if (v[i]) lanes.push_back(dat[8*i +: 8]);
    foreach (lanes[k]) b.data[k] = lanes[k];
    b.cnt = 3'(lanes.size());
    return b;
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] c);
    int unsigned m;
    m = (32'd1 << c) - 1;
    return m[3:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check head/occupancy/ready at negedge, advance model at posedge.
  task automatic cycle(input int d, input logic [3:0] v, input logic [31:0] dat,
                       input logic rdy, input logic clr, output logic acc);
    beat_t hd;
    logic  exp_rdy;
    valid_i[d] = v;
    data_i[d]  = dat;
    ready_i[d] = rdy;
    clear_i[d] = clr;
    @(negedge clk);
    exp_rdy = !clr && ((q.size() < depth_m) || rdy);
    hd = '0;
    if (q.size() > 0) hd = q[0];
    chk("ready_o", 32'(ready_o[d]), 32'(exp_rdy));
    chk("usage_o", 32'(usage_o[d]), q.size());
    chk("cnt_o",   32'(cnt_o[d]),   32'(hd.cnt));
    chk("valid_o", 32'(valid_o[d]), 32'(mask_of(hd.cnt)));
    chk("data_o",  data_o[d],       hd.data);
    acc = (|v) && exp_rdy;
    @(posedge clk);
    if (clr) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) q.push_back(compact(v, dat));
    end
    #1;
  endtask

  task automatic drain(input int d);
    logic acc;
    for (int n = 0; n < 8 && q.size() > 0; n++) cycle(d, 4'b0, 32'h0, 1'b1, 1'b0, acc);
    cycle(d, 4'b0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic suite(input int d, input int unsigned depth);
    logic        acc;
    logic        pend;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        rr;
    logic        rc;
    depth_m = depth;
    q.delete();

    phase = $sformatf("d%0d.reset", depth);
    valid_i[d] = '0; data_i[d] = '0; ready_i[d] = 1'b0; clear_i[d] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 32'(ready_o[d]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(d, 4'b0, 32'h0, 1'b0, 1'b0, acc);

    phase = $sformatf("d%0d.compact", depth);
    cycle(d, 4'b1010, 32'h44332211, 1'b0, 1'b0, acc);
    chk("head_data",  data_o[d],        32'h00004422);
    chk("head_cnt",   32'(cnt_o[d]),    32'd2);
    chk("head_valid", 32'(valid_o[d]),  32'h3);
    drain(d);

    phase = $sformatf("d%0d.backpressure", depth);
    cycle(d, 4'b0001, 32'h000000A1, 1'b0, 1'b0, acc);
    cycle(d, 4'b0110, 32'h00B2B100, 1'b0, 1'b0, acc);
    cycle(d, 4'b1111, 32'hC4C3C2C1, 1'b0, 1'b0, acc);
    for (int n = 0; n < 4 && !acc; n++) cycle(d, 4'b1111, 32'hC4C3C2C1, 1'b1, 1'b0, acc);
    drain(d);

    phase = $sformatf("d%0d.fullpushpop", depth);
    for (int unsigned n = 0; n < depth; n++) cycle(d, 4'b0011, 32'h0000D0D0 + n, 1'b0, 1'b0, acc);
    cycle(d, 4'b0100, 32'h11772233, 1'b1, 1'b0, acc);
    drain(d);

    phase = $sformatf("d%0d.clear", depth);
    cycle(d, 4'b0101, 32'h00E100E0, 1'b0, 1'b0, acc);
    cycle(d, 4'b1001, 32'hF3000000 | 32'h000000F0, 1'b0, 1'b0, acc);
    cycle(d, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1, acc);
    cycle(d, 4'b0, 32'h0, 1'b0, 1'b0, acc);
    cycle(d, 4'b0011, 32'h00002A1A, 1'b0, 1'b0, acc);
    drain(d);

    phase = $sformatf("d%0d.edgemask", depth);
    cycle(d, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b0, acc);
    cycle(d, 4'b1111, 32'h5A6B7C8D, 1'b0, 1'b0, acc);
    cycle(d, 4'b1000, 32'h9E000000, 1'b0, 1'b0, acc);
    for (int n = 0; n < 4 && !acc; n++) cycle(d, 4'b1000, 32'h9E000000, 1'b1, 1'b0, acc);
    drain(d);

    phase = $sformatf("d%0d.random", depth);
    pend = 1'b0;
    rv = '0;
    rd = '0;
    for (int n = 0; n < 150; n++) begin
      if (!pend) begin
        rv = 4'($urandom);
        rd = $urandom;
      end
      rr = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 31) == 0);
      cycle(d, rv, rd, rr, rc, acc);
      pend = (|rv) && !acc && !rc;
    end
    for (int n = 0; n < 4 && pend; n++) begin
      cycle(d, rv, rd, 1'b1, 1'b0, acc);
      pend = !acc;
    end
    drain(d);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid_i[i] = '0;
      data_i[i]  = '0;
      ready_i[i] = 1'b0;
      clear_i[i] = 1'b0;
    end
    suite(0, 2);
    suite(1, 3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not complete");
  end

endmodule
